// File: rtl/bitty_fetch_sequencer.sv
// bitty_fetch_sequencer: fetches 16-bit instructions, resolves branches locally and issues the rest to the Bitty core
module bitty_fetch_sequencer #(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              cpu_done,
  input  logic [2:0]        cmp_flags,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       retired
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH    = 3'd1;
  localparam logic [2:0] WAIT_MEM = 3'd2;
  localparam logic [2:0] DECODE   = 3'd3;
  localparam logic [2:0] ISSUE    = 3'd4;
  localparam logic [2:0] HALTED   = 3'd5;
  logic [2:0]        state;
  logic [15:0]       ir;
  logic [7:0]        tgt8;
  logic [ADDR_W-1:0] target;
  logic              taken;
  assign tgt8        = ir[11:4];
  assign target      = tgt8[ADDR_W-1:0];
  // cmp_flags is {lt,gt,eq}; cond 11 never branches
  assign taken       = ir[3:2] == 2'b00 ? cmp_flags[0] :
                       ir[3:2] == 2'b01 ? cmp_flags[1] :
                       ir[3:2] == 2'b10 ? cmp_flags[2] : 1'b0;
  assign mem_addr    = pc;
  assign mem_rd_en   = state == FETCH;
  assign instr_valid = state == ISSUE;
  assign halted      = state == HALTED;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      instr   <= '0;
      retired <= '0;
    end else begin
      case (state)
        IDLE:     if (start) state <= FETCH;
        FETCH:    state <= WAIT_MEM;
        WAIT_MEM: if (mem_rvalid) begin
          ir    <= mem_rdata;
          state <= DECODE;
        end
        DECODE:   if (ir == HALT_WORD) state <= HALTED;
        else if (ir[1:0] == 2'b10) begin
          pc    <= taken ? target : pc + ADDR_W'(1);
          state <= FETCH;
        end else begin
          instr <= ir;
          state <= ISSUE;
        end
        ISSUE:    if (cpu_done) begin
          pc      <= pc + ADDR_W'(1);
          retired <= retired == 16'hFFFF ? retired : retired + 16'd1;
          state   <= FETCH;
        end
        HALTED:   if (start) begin
          pc    <= '0;
          state <= FETCH;
        end
        default:  state <= IDLE;
      endcase
    end
endmodule
